// File: rtl/sbox_share_arb.sv
// sbox_share_arb: time-shares one byte-wide S-box between the key-schedule
// requester (SubWord, 4 bytes) and the round datapath (SubBytes, 16 bytes).
// One job at a time, one byte per cycle, results reassembled in place.
// Optional macro SBOX_SHARE_INV_EN: when defined, sbox_inv follows the job's
// direction bit; otherwise sbox_inv is tied to 0 and *_inv inputs are ignored.
module sbox_share_arb #(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ks_valid,
  output logic         ks_ready,
  input  logic [31:0]  ks_word,
  input  logic         ks_inv,
  output logic         ks_done,
  output logic [31:0]  ks_result,
  input  logic         dp_valid,
  output logic         dp_ready,
  input  logic [127:0] dp_state,
  input  logic         dp_inv,
  output logic         dp_done,
  output logic [127:0] dp_result,
  output logic [7:0]   sbox_in,
  output logic         sbox_inv,
  input  logic [7:0]   sbox_out
);

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned TAG_W    = IDX_W + 1;
  localparam int unsigned PIPE_D   = (SBOX_LAT == 0) ? 1 : SBOX_LAT;
  localparam int unsigned TAG_BITS = PIPE_D * TAG_W;
  // Tags that will still be in flight after the current cycle (all but the emerging one).
  localparam logic [PIPE_D-1:0] PEND_MASK = {PIPE_D{1'b1}} >> 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state, state_nxt;
  logic [DATA_W-1:0]       job_data;
  logic [IDX_W-1:0]        job_last;
  logic                    job_dp;
  logic [IDX_W-1:0]        issue_idx;
  logic [PIPE_D-1:0][TAG_W-1:0] tag_q;
  logic [PIPE_D-1:0]       tag_v;
  logic [TAG_W-1:0]        cap_c;
  logic [IDX_W-1:0]        idx_inc_c;
  logic [7:0]              sbox_in_nxt_c;
  logic                    ks_acc_c, dp_acc_c, last_c, pending_c;

  // Handshake: key schedule wins ties; nothing is accepted during reset or mid-job.
  assign ks_ready  = (state == IDLE) & ~rst;
  assign dp_ready  = (state == IDLE) & ~rst & ~ks_valid;
  assign ks_acc_c  = ks_valid & ks_ready;
  assign dp_acc_c  = dp_valid & dp_ready;
  assign last_c    = (issue_idx == job_last);
  assign idx_inc_c = issue_idx + IDX_W'(1);
  assign pending_c = |(tag_v & PEND_MASK);

  for (genvar k = 0; k < PIPE_D; k++) begin : g_tag_v
    assign tag_v[k] = tag_q[k][IDX_W];
  end

  // Tag emerging alongside sbox_out; combinational S-box captures in the issue cycle.
  if (SBOX_LAT == 0) begin : g_cap_comb
    assign cap_c = {state == ISSUE, issue_idx};
  end else begin : g_cap_pipe
    assign cap_c = tag_q[PIPE_D-1];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next issued byte.
  always_comb begin
    state_nxt     = state;
    sbox_in_nxt_c = 8'h00;
    case (state)
      IDLE: begin
        if (ks_acc_c) begin
          state_nxt     = ISSUE;
          sbox_in_nxt_c = ks_word[7:0];
        end else if (dp_acc_c) begin
          state_nxt     = ISSUE;
          sbox_in_nxt_c = dp_state[7:0];
        end
      end
      ISSUE: begin
        if (last_c) state_nxt = (SBOX_LAT == 0) ? DONE : DRAIN;
        else        sbox_in_nxt_c = job_data[{idx_inc_c, 3'b000} +: 8];
      end
      DRAIN: begin
        if (!pending_c) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag shift register tracking {valid, idx} through the S-box latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= TAG_BITS'({tag_q, state == ISSUE, issue_idx});
  end

  // Job buffer, issue counter, byte capture and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_data  <= '0;
      job_last  <= '0;
      job_dp    <= 1'b0;
      issue_idx <= '0;
      sbox_in   <= 8'h00;
      ks_done   <= 1'b0;
      dp_done   <= 1'b0;
      ks_result <= '0;
      dp_result <= '0;
    end else begin
      sbox_in <= sbox_in_nxt_c;
      ks_done <= (state_nxt == DONE) & ~job_dp;
      dp_done <= (state_nxt == DONE) &  job_dp;
      if (ks_acc_c || dp_acc_c) begin
        job_data  <= ks_acc_c ? {96'b0, ks_word} : dp_state;
        job_last  <= ks_acc_c ? IDX_W'(3) : IDX_W'(15);
        job_dp    <= ~ks_acc_c;
        issue_idx <= '0;
      end else if (state == ISSUE && !last_c) begin
        issue_idx <= idx_inc_c;
      end
      if (cap_c[IDX_W]) begin
        if (job_dp) dp_result[{cap_c[IDX_W-1:0], 3'b000} +: 8] <= sbox_out;
        else        ks_result[{cap_c[1:0], 3'b000} +: 8]       <= sbox_out;
      end
    end
  end

`ifdef SBOX_SHARE_INV_EN
  logic job_inv, inv_nxt_c;

  // Direction follows the job from first issue through drain, 0 otherwise.
  always_comb begin
    inv_nxt_c = 1'b0;
    if (ks_acc_c)      inv_nxt_c = ks_inv;
    else if (dp_acc_c) inv_nxt_c = dp_inv;
    else if (state_nxt == ISSUE || state_nxt == DRAIN) inv_nxt_c = job_inv;
  end

  // Captured direction and registered sbox_inv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_inv  <= 1'b0;
      sbox_inv <= 1'b0;
    end else begin
      if (ks_acc_c)      job_inv <= ks_inv;
      else if (dp_acc_c) job_inv <= dp_inv;
      sbox_inv <= inv_nxt_c;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = ks_inv ^ dp_inv;
  assign sbox_inv   = 1'b0;
`endif

endmodule
